// File: rtl/cpu68k_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : cpu68k_bus_master
// Purpose  : Initiator for the 68k-style peripheral bus. Accepts single-byte
//            read/write requests on a valid/ready port, sequences CS, DS, RW
//            and the 8-bit data bus, waits for the active-low DTACK and
//            returns read data or a timeout error on a one-cycle strobe.
// Ports    : clk, rst_n              - clock, async active-low reset
//            req_valid/req_ready     - request handshake (ready only in IDLE)
//            req_rw, req_wdata       - request type (1=read) and write byte
//            rsp_valid/rsp_rdata/rsp_err - one-cycle response
//            cs, ds, rw, data_out, data_oe - bus outputs (all registered)
//            data_in, dtack_n        - bus inputs from the responder
// Revision : 1.0 - initial release
// ============================================================================
module cpu68k_bus_master #(
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       cs,
    output logic       ds,
    output logic       rw,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    input  logic       dtack_n
);

    // One counter serves both SETUP and the STROBE/RELEASE timeouts, so it
    // is sized for whichever limit is larger.
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_SU_W  = $clog2(SETUP_CYCLES + 1);
    localparam int c_CNT_W = (c_TO_W > c_SU_W) ? c_TO_W : c_SU_W;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SU_LAST  = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [c_CNT_W-1:0] cnt_q,       cnt_d;
    logic               cs_q,        cs_d;
    logic               ds_q,        ds_d;
    logic               rw_q,        rw_d;
    logic [7:0]         data_out_q,  data_out_d;
    logic               data_oe_q,   data_oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= c_CNT_ZERO;
            cs_q        <= 1'b0;
            ds_q        <= 1'b0;
            rw_q        <= 1'b1;
            data_out_q  <= 8'h00;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            ds_q        <= ds_d;
            rw_q        <= rw_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cs_d        = cs_q;
        ds_d        = ds_q;
        rw_d        = rw_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        // Response fields are a pure one-cycle pulse: zero unless set below.
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 8'h00;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cs_d       = 1'b1;
                    ds_d       = 1'b0;
                    rw_d       = req_rw;
                    data_out_d = req_rw ? 8'h00 : req_wdata;
                    data_oe_d  = ~req_rw;
                    cnt_d      = c_CNT_ZERO;
                    state_d    = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == c_SU_LAST) begin
                    ds_d    = 1'b1;
                    cnt_d   = c_CNT_ZERO;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_STROBE: begin
                // DTACK is tested first so an ack on the final timeout edge
                // completes normally instead of raising an error.
                if (!dtack_n || (cnt_q == c_TO_LAST)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = dtack_n;
                    rsp_rdata_d = (!dtack_n && rw_q) ? data_in : 8'h00;
                    cs_d        = 1'b0;
                    ds_d        = 1'b0;
                    data_oe_d   = 1'b0;
                    data_out_d  = 8'h00;
                    cnt_d       = c_CNT_ZERO;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            ST_RELEASE: begin
                // Wait for the responder to let go of DTACK, but never hang on
                // a stuck-low DTACK; that case is silently abandoned.
                if (dtack_n || (cnt_q == c_TO_LAST)) begin
                    rw_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cs        = cs_q;
    assign ds        = ds_q;
    assign rw        = rw_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu68k_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu68k_bus_master
// Purpose  : Directed self-checking bench for cpu68k_bus_master with
//            SETUP_CYCLES=1, TIMEOUT_CYCLES=4 and a behavioural responder
//            whose DTACK latency is programmable (0 = never acknowledge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu68k_bus_master;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       cs;
    logic       ds;
    logic       rw;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       dtack_n;

    int errors;
    int checks;

    int         resp_lat;
    logic [7:0] resp_data;
    int         ack_cnt;

    cpu68k_bus_master #(
        .SETUP_CYCLES   (1),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .cs        (cs),
        .ds        (ds),
        .rw        (rw),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .dtack_n   (dtack_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: counts edges on which it sees cs && ds and pulls DTACK low
    // (with read data) once that count reaches resp_lat; releases as soon as
    // it sees the select drop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dtack_n <= 1'b1;
            data_in <= 8'h00;
            ack_cnt <= 0;
        end else if (cs && ds) begin
            if (resp_lat != 0 && ack_cnt + 1 >= resp_lat) begin
                dtack_n <= 1'b0;
                data_in <= resp_data;
            end
            ack_cnt <= ack_cnt + 1;
        end else begin
            dtack_n <= 1'b1;
            ack_cnt <= 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_rw = 1'b1; req_wdata = 8'h00;
        resp_lat = 0; resp_data = 8'h00;
        #12;
        checks++;
        if (cs !== 1'b0 || ds !== 1'b0 || rw !== 1'b1 || data_out !== 8'h00 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: cs=%b ds=%b rw=%b data_out=%h oe=%b, want 0 0 1 00 0", cs, ds, rw, data_out, data_oe);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b ready=%b, want 0 00 0 1", rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        resp_lat = 1;
        req_rw = 1'b0; req_wdata = 8'hA5; req_valid = 1'b1;
        step();                                  // E0
        req_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin        // after E0, E1, E2
            checks++;
            if (cs !== 1'b1 || data_oe !== 1'b1 || data_out !== 8'hA5 || rw !== 1'b0 || ds !== (e >= 1) || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_bus_e%0d: cs=%b oe=%b data=%h rw=%b ds=%b ready=%b, want 1 1 a5 0 %b 0", e, cs, data_oe, data_out, rw, ds, req_ready, (e >= 1));
            end
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL write_early_rsp_e%0d: rsp_valid=%b, want 0", e, rsp_valid);
            end
            step();
        end
        // after E3
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00 || cs !== 1'b0 || ds !== 1'b0 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: valid=%b err=%b rdata=%h cs=%b ds=%b oe=%b, want 1 0 00 0 0 0", rsp_valid, rsp_err, rsp_rdata, cs, ds, data_oe);
        end
        step();                                  // E4
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_e4: valid=%b ready=%b, want 0 0", rsp_valid, req_ready);
        end
        step();                                  // E5
        checks++;
        if (req_ready !== 1'b1 || rw !== 1'b1) begin
            errors++;
            $display("FAIL write_ready_e5: ready=%b rw=%b, want 1 1", req_ready, rw);
        end
    endtask

    task automatic test_read();
        resp_lat = 1; resp_data = 8'h3C;
        req_rw = 1'b1; req_wdata = 8'hEE; req_valid = 1'b1;
        step();                                  // E0
        req_valid = 1'b0;
        for (int e = 0; e < 6; e++) begin        // after E0..E5
            checks++;
            if (rw !== 1'b1 || data_oe !== 1'b0) begin
                errors++;
                $display("FAIL read_rw_oe_e%0d: rw=%b oe=%b, want 1 0", e, rw, data_oe);
            end
            checks++;
            if (rsp_valid !== (e == 3)) begin
                errors++;
                $display("FAIL read_rsp_valid_e%0d: valid=%b, want %b", e, rsp_valid, (e == 3));
            end
            if (e == 3) begin
                checks++;
                if (rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL read_data: rdata=%h err=%b, want 3c 0", rsp_rdata, rsp_err);
                end
            end
            if (e < 5) step();
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_ready: ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_timeout();
        resp_lat = 0;
        req_rw = 1'b1; req_valid = 1'b1;
        step();                                  // E0
        req_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin       // after E1..E4: ds held
            step();
            checks++;
            if (ds !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_ds_e%0d: ds=%b valid=%b, want 1 0", e, ds, rsp_valid);
            end
        end
        step();                                  // E5
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || ds !== 1'b0 || cs !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h ds=%b cs=%b, want 1 1 00 0 0", rsp_valid, rsp_err, rsp_rdata, ds, cs);
        end
        step();                                  // E6
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_dtack_last_edge();
        resp_lat = 3; resp_data = 8'h5A;
        req_rw = 1'b1; req_valid = 1'b1;
        step();                                  // E0
        req_valid = 1'b0;
        for (int e = 1; e <= 4; e++) step();     // E1..E4
        checks++;
        if (rsp_valid !== 1'b0 || ds !== 1'b1) begin
            errors++;
            $display("FAIL last_edge_pre: valid=%b ds=%b, want 0 1", rsp_valid, ds);
        end
        step();                                  // E5: final timeout edge
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL last_edge_rsp: valid=%b err=%b rdata=%h, want 1 0 5a", rsp_valid, rsp_err, rsp_rdata);
        end
        step();                                  // E6: DTACK still low
        step();                                  // E7
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL last_edge_idle: ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        resp_lat = 1; resp_data = 8'h77;
        req_rw = 1'b0; req_wdata = 8'h11; req_valid = 1'b1;
        step();                                  // E0: write accepted
        req_wdata = 8'hFF; req_rw = 1'b1;        // next request, held pending
        for (int e = 0; e < 3; e++) begin        // after E0..E2
            checks++;
            if (data_out !== 8'h11 || rw !== 1'b0 || data_oe !== 1'b1) begin
                errors++;
                $display("FAIL b2b_wdata_e%0d: data=%h rw=%b oe=%b, want 11 0 1", e, data_out, rw, data_oe);
            end
            step();
        end
        checks++;                                // after E3
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_rsp: valid=%b err=%b, want 1 0", rsp_valid, rsp_err);
        end
        step();                                  // E4
        step();                                  // E5: IDLE re-entry
        checks++;
        if (req_ready !== 1'b1 || cs !== 1'b0) begin
            errors++;
            $display("FAIL b2b_not_early: ready=%b cs=%b, want 1 0", req_ready, cs);
        end
        step();                                  // E6: read accepted
        req_valid = 1'b0;
        checks++;
        if (cs !== 1'b1 || rw !== 1'b1 || data_oe !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept: cs=%b rw=%b oe=%b ready=%b, want 1 1 0 0", cs, rw, data_oe, req_ready);
        end
        step(); step(); step();                  // E7..E9
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h77 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_rsp: valid=%b rdata=%h err=%b, want 1 77 0", rsp_valid, rsp_rdata, rsp_err);
        end
        step(); step();                          // E10, E11
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_final_idle: ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int waited;
        resp_lat = 0;
        req_rw = 1'b1; req_valid = 1'b1;
        step();                                  // E0
        req_valid = 1'b0;
        step(); step();                          // E1, E2: in STROBE
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cs !== 1'b0 || ds !== 1'b0 || data_oe !== 1'b0 || rsp_valid !== 1'b0 || rw !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: cs=%b ds=%b oe=%b valid=%b rw=%b ready=%b, want 0 0 0 0 1 1", cs, ds, data_oe, rsp_valid, rw, req_ready);
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: rsp_valid pulses=%0d, want 0", seen);
        end
        resp_lat = 1; resp_data = 8'hC3;
        req_rw = 1'b1; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3 || rsp_err !== 1'b0 || waited != 3) begin
            errors++;
            $display("FAIL reset_mid_recover: valid=%b rdata=%h err=%b edges=%0d, want 1 c3 0 3", rsp_valid, rsp_rdata, rsp_err, waited);
        end
        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_idle: ready=%b, want 1", req_ready);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_dtack_last_edge();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
